// File: rtl/stopwatch_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | stopwatch_core: BCD MM:SS.cc stopwatch with run/pause/lap control.    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module stopwatch_core #(
  parameter int MIN_LIMIT = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       btn_ss_i,
  input  logic       btn_lap_i,
  input  logic       btn_clr_i,
  output logic [7:0] disp_cs_o,
  output logic [7:0] disp_sec_o,
  output logic [7:0] disp_min_o,
  output logic       running_o,
  output logic       lap_hold_o,
  output logic       ovf_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_PAUSE  = 2'd2;
  localparam logic [1:0] S_LAPRUN = 2'd3;

  localparam logic [3:0] c_MIN_T = 4'(MIN_LIMIT / 10);
  localparam logic [3:0] c_MIN_U = 4'(MIN_LIMIT % 10);

  logic [1:0]  state_q, state_d;
  // Packed digits {min_t, min_u, sec_t, sec_u, cs_t, cs_u}
  logic [23:0] cnt_q, cnt_d;
  logic [23:0] lap_q, lap_d;
  logic        ovf_q, ovf_d;

  logic w_count;
  logic w_min_at_limit;
  logic w_wrap;
  logic w_lap_entry;

  assign w_count        = tick_i & ~btn_clr_i & ((state_q == S_RUN) | (state_q == S_LAPRUN));
  assign w_min_at_limit = (cnt_q[23:20] == c_MIN_T) && (cnt_q[19:16] == c_MIN_U);
  assign w_wrap         = w_count && w_min_at_limit && (cnt_q[15:0] == 16'h5999);
  assign w_lap_entry    = (state_d == S_LAPRUN) && (state_q != S_LAPRUN);

  always_comb begin
    state_d = state_q;
    if (btn_clr_i) begin
      state_d = S_IDLE;
    end else if (btn_ss_i) begin
      case (state_q)
        S_RUN, S_LAPRUN: state_d = S_PAUSE;
        default:         state_d = S_RUN;
      endcase
    end else if (btn_lap_i) begin
      case (state_q)
        S_RUN:    state_d = S_LAPRUN;
        S_LAPRUN: state_d = S_RUN;
        default:  state_d = state_q;
      endcase
    end
  end

  // Ripple carry through the digit chain; each digit only ever steps within BCD range.
  always_comb begin
    cnt_d = cnt_q;
    if (btn_clr_i) begin
      cnt_d = '0;
    end else if (w_count) begin
      if (cnt_q[3:0] != 4'd9) begin
        cnt_d[3:0] = cnt_q[3:0] + 4'd1;
      end else begin
        cnt_d[3:0] = '0;
        if (cnt_q[7:4] != 4'd9) begin
          cnt_d[7:4] = cnt_q[7:4] + 4'd1;
        end else begin
          cnt_d[7:4] = '0;
          if (cnt_q[11:8] != 4'd9) begin
            cnt_d[11:8] = cnt_q[11:8] + 4'd1;
          end else begin
            cnt_d[11:8] = '0;
            if (cnt_q[15:12] != 4'd5) begin
              cnt_d[15:12] = cnt_q[15:12] + 4'd1;
            end else begin
              cnt_d[15:12] = '0;
              if (w_min_at_limit) begin
                cnt_d[23:16] = '0;
              end else if (cnt_q[19:16] != 4'd9) begin
                cnt_d[19:16] = cnt_q[19:16] + 4'd1;
              end else begin
                cnt_d[19:16] = '0;
                cnt_d[23:20] = cnt_q[23:20] + 4'd1;
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    lap_d = lap_q;
    ovf_d = ovf_q;
    if (btn_clr_i) begin
      lap_d = '0;
      ovf_d = 1'b0;
    end else begin
      if (w_lap_entry) lap_d = cnt_d;
      if (w_wrap)      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lap_q   <= lap_d;
      ovf_q   <= ovf_d;
    end
  end

  // Displays are purely combinational from registers so async reset clears them at once.
  logic [23:0] w_disp;
  assign w_disp     = (state_q == S_LAPRUN) ? lap_q : cnt_q;
  assign disp_min_o = w_disp[23:16];
  assign disp_sec_o = w_disp[15:8];
  assign disp_cs_o  = w_disp[7:0];
  assign running_o  = (state_q == S_RUN) || (state_q == S_LAPRUN);
  assign lap_hold_o = (state_q == S_LAPRUN);
  assign ovf_o      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_stopwatch_core: directed + random bench against a time-in-cs model.|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_stopwatch_core;

  localparam int LIM = 10;
  localparam int MOD = (LIM + 1) * 6000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
  logic [7:0] disp_cs, disp_sec, disp_min;
  logic       running, lap_hold, ovf;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: elapsed time in centiseconds plus two behavioural flags.
  int m_total = 0;
  int m_lap   = 0;
  bit m_run   = 1'b0;
  bit m_hold  = 1'b0;
  bit m_ovf   = 1'b0;

  stopwatch_core #(.MIN_LIMIT(LIM)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_i     (tick),
    .btn_ss_i   (btn_ss),
    .btn_lap_i  (btn_lap),
    .btn_clr_i  (btn_clr),
    .disp_cs_o  (disp_cs),
    .disp_sec_o (disp_sec),
    .disp_min_o (disp_min),
    .running_o  (running),
    .lap_hold_o (lap_hold),
    .ovf_o      (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int x);
    logic [7:0] r;
    r[7:4] = 4'(x / 10);
    r[3:0] = 4'(x % 10);
    return r;
  endfunction

  function automatic logic [23:0] time_bcd(input int v);
    return {bcd(v / 6000), bcd((v / 100) % 60), bcd(v % 100)};
  endfunction

  function automatic logic [31:0] model_vec();
    int v;
    v = m_hold ? m_lap : m_total;
    return {5'd0, time_bcd(v), m_run, m_hold, m_ovf};
  endfunction

  function automatic logic [31:0] dut_vec();
    return {5'd0, disp_min, disp_sec, disp_cs, running, lap_hold, ovf};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_total = 0; m_lap = 0; m_run = 0; m_hold = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit t, input bit s, input bit l, input bit c);
    if (c) begin
      model_reset();
    end else begin
      if (m_run && t) begin
        m_total = m_total + 1;
        if (m_total == MOD) begin
          m_total = 0;
          m_ovf   = 1;
        end
      end
      if (s) begin
        if (m_run) begin m_run = 0; m_hold = 0; end
        else m_run = 1;
      end else if (l && m_run) begin
        m_hold = !m_hold;
        if (m_hold) m_lap = m_total;
      end
    end
  endtask

  // Drive one cycle of inputs, apply the edge to the model, compare just after the edge.
  task automatic step(input bit t, input bit s, input bit l, input bit c);
    tick = t; btn_ss = s; btn_lap = l; btn_clr = c;
    @(posedge clk);
    model_edge(t, s, l, c);
    #1;
    tick = 0; btn_ss = 0; btn_lap = 0; btn_clr = 0;
    check("cycle", dut_vec(), model_vec());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held with activity on every input
    tick = 1; btn_ss = 1; btn_lap = 1; btn_clr = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", dut_vec(), 32'h0);
    tick = 0; btn_ss = 0; btn_lap = 0;
    rst = 0;
    step(1, 0, 0, 0);
    check("idle_first_edge", dut_vec(), 32'h0);

    // Start with coincident tick, then 150 ticks
    step(1, 1, 0, 0);
    check("ss_tick_not_counted", {8'h0, disp_min, disp_sec, disp_cs}, 32'h000000);
    ticks(150);
    check("start_count", dut_vec(), {5'd0, 24'h000150, 3'b100});

    // Lap freeze at 00:02.37
    ticks(87);
    step(0, 0, 1, 0);
    ticks(50);
    check("lap_frozen", dut_vec(), {5'd0, 24'h000237, 3'b110});
    step(0, 0, 1, 0);
    check("lap_release", dut_vec(), {5'd0, 24'h000287, 3'b100});

    // Priority
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(500);
    check("at_5s", dut_vec(), {5'd0, 24'h000500, 3'b100});
    step(1, 1, 1, 1);
    check("clr_wins", dut_vec(), 32'h0);
    step(0, 1, 0, 0);
    ticks(3);
    step(0, 1, 1, 0);
    check("ss_over_lap", dut_vec(), {5'd0, 24'h000003, 3'b000});

    // Pause with coincident tick
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(10);
    step(1, 1, 0, 0);
    check("pause_tick", dut_vec(), {5'd0, 24'h000011, 3'b000});
    ticks(20);
    step(0, 0, 1, 0);
    check("paused_hold", dut_vec(), {5'd0, 24'h000011, 3'b000});
    step(0, 1, 0, 0);
    ticks(5);
    check("resume", dut_vec(), {5'd0, 24'h000016, 3'b100});

    // Lap then ss reverts display to live count
    step(0, 0, 1, 0);
    ticks(7);
    step(0, 1, 0, 0);
    check("laprun_to_pause", dut_vec(), {5'd0, 24'h000023, 3'b000});

    // Asynchronous reset at 01:23.45
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    ticks(8345);
    step(0, 0, 1, 0);
    check("at_1_23_45", dut_vec(), {5'd0, 24'h012345, 3'b110});
    #2 rst = 1;
    #1;
    check("async_reset", dut_vec(), 32'h0);
    model_reset();
    @(posedge clk);
    #1 rst = 0;
    step(1, 0, 1, 0);
    check("post_reset_idle", dut_vec(), 32'h0);

    // Wrap from LIM:59.99
    step(0, 1, 0, 0);
    ticks(MOD - 1);
    check("at_limit", dut_vec(), {5'd0, bcd(LIM), 16'h5999, 3'b100});
    ticks(1);
    check("wrap", dut_vec(), {5'd0, 24'h000000, 3'b101});
    ticks(12);
    check("ovf_sticky", dut_vec(), {5'd0, 24'h000012, 3'b101});
    step(0, 0, 0, 1);
    check("clr_ovf", dut_vec(), 32'h0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step(bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 19) == 0),
           bit'($urandom_range(0, 14) == 0),
           bit'($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_core.md
STOPWATCH_CORE -- requirements
Module: stopwatch_core

Interface
REQ-001 Parameter MIN_LIMIT, default 59, SHALL be the highest minute value before wrap-around (range 1..99).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 tick  input  1  0.01 s strobe from the upstream pulse generator; high for exactly one clk cycle and synchronous to clk.
REQ-005 btn_ss  input  1  start/stop request; single-cycle pulse, already debounced.
REQ-006 btn_lap  input  1  lap freeze/release request; single-cycle pulse.
REQ-007 btn_clr  input  1  clear request; single-cycle pulse.
REQ-008 disp_cs  output  8  displayed centiseconds, packed BCD {tens,units}, 00..99.
REQ-009 disp_sec  output  8  displayed seconds, packed BCD, 00..59.
REQ-010 disp_min  output  8  displayed minutes, packed BCD, 00..MIN_LIMIT.
REQ-011 running  output  1  high in RUN and LAPRUN.
REQ-012 lap_hold  output  1  high in LAPRUN.
REQ-013 ovf  output  1  sticky flag set on wrap from MIN_LIMIT:59.99.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, PAUSE and LAPRUN.
REQ-015 Transitions SHALL be: IDLE -ss-> RUN; RUN -ss-> PAUSE; RUN -lap-> LAPRUN; LAPRUN -lap-> RUN; LAPRUN -ss-> PAUSE; PAUSE -ss-> RUN; any state -clr-> IDLE.
REQ-016 Buttons with no listed transition for the current state SHALL be ignored (e.g. lap in IDLE or PAUSE).
REQ-017 Simultaneous buttons SHALL be prioritised clr > ss > lap; only the highest-priority button SHALL take effect.
REQ-018 The live count SHALL advance by 0.01 s on every clk edge where tick=1 and the current (pre-edge) state is RUN or LAPRUN, including when ss or lap is present in the same cycle.
REQ-019 A tick coinciding with ss in IDLE or PAUSE SHALL NOT be counted.
REQ-020 A tick coinciding with clr SHALL NOT be counted; clr wins.
REQ-021 Each digit SHALL be an independent 4-bit BCD counter, with carry chain cs units 9->0 to cs tens, cs 99->00 to sec units, sec 59->00 to min, and min MIN_LIMIT->00.
REQ-022 Digits SHALL never hold non-BCD codes (A..F).
REQ-023 When the count rolls from MIN_LIMIT:59.99 to 00:00.00, ovf SHALL set on that edge and hold until clr or rst; counting SHALL continue.
REQ-024 On entry to LAPRUN, a lap register SHALL capture the post-edge live count value, and the displays SHALL show the lap register while in LAPRUN.
REQ-025 In all other states, the displays SHALL show the live count directly, with zero added latency after the updating edge.
REQ-026 On LAPRUN -ss-> PAUSE, the displays SHALL revert to the live count.
REQ-027 clr SHALL zero the live count, the lap register and ovf on the same edge it is sampled.
REQ-028 tick and buttons SHALL have no effect while rst=1.

Reset
REQ-029 While rst=1, the block SHALL hold state=IDLE, all digits=0, lap register=0, disp_*=8'h00, running=0, lap_hold=0 and ovf=0, independent of clk.
REQ-030 After rst deasserts, the first edge SHALL behave as a normal IDLE cycle.
REQ-031 rst asserted mid-count SHALL discard the count and lap with no partial carry.

Verification
REQ-032 Start/count: ss pulse, then 150 ticks -> disp 00:01.50, running=1; a tick coincident with the ss pulse is not counted.
REQ-033 Carry/wrap: preload via 3599 s + 99 ticks to 59:59.99 with MIN_LIMIT=59, one tick -> 00:00.00, ovf=1; clr -> ovf=0.
REQ-034 Lap: at 00:02.37 press lap, then 50 ticks -> disp stays 00:02.37, lap_hold=1; lap again -> disp 00:02.87.
REQ-035 Priority: ss+lap+clr in the same cycle in RUN at 00:05.00 -> IDLE, 00:00.00, running=0; ss+lap in RUN -> PAUSE, not LAPRUN.
REQ-036 Pause: ss in RUN at 00:00.10 with a coincident tick -> PAUSE at 00:00.11; 20 further ticks -> unchanged; ss -> resumes counting.
REQ-037 Async reset: assert rst between clk edges at 01:23.45 -> outputs 00:00.00, running=0 immediately, before the next clk edge.
